// File: rtl/updown_counter_pkg.sv
// Shared types for the parametrised up/down counter.
package updown_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/ud_next_calc.sv
// Combinational next-count and overflow/underflow event calculation.
module ud_next_calc
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [STEP_W-1:0] i_step,
  input  dir_e              i_dir,
  input  mode_e             i_mode,
  input  logic [WIDTH-1:0]  i_min,
  input  logic [WIDTH-1:0]  i_max,
  output logic [WIDTH-1:0]  o_next,
  output logic              o_ovf_evt,
  output logic              o_unf_evt
);

  logic [WIDTH:0]   w_count_x;
  logic [WIDTH:0]   w_step_x;
  logic [WIDTH:0]   w_min_x;
  logic [WIDTH:0]   w_max_x;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_floor;
  logic [WIDTH-1:0] w_diff;

  // One guard bit keeps sum/floor from aliasing back into range.
  assign w_count_x = {1'b0, i_count};
  assign w_step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
  assign w_min_x   = {1'b0, i_min};
  assign w_max_x   = {1'b0, i_max};
  assign w_sum     = w_count_x + w_step_x;
  assign w_floor   = w_min_x + w_step_x;
  assign w_diff    = i_count - w_step_x[WIDTH-1:0];

  always_comb begin
    o_next    = i_count;
    o_ovf_evt = 1'b0;
    o_unf_evt = 1'b0;
    if (i_dir == DIR_UP) begin
      if (w_sum <= w_max_x) begin
        o_next = w_sum[WIDTH-1:0];
      end else begin
        o_ovf_evt = 1'b1;
        o_next    = (i_mode == MODE_SAT) ? i_max : i_min;
      end
    end else begin
      if (w_count_x < w_floor) begin
        o_unf_evt = 1'b1;
        o_next    = (i_mode == MODE_SAT) ? i_min : i_max;
      end else begin
        o_next = w_diff;
      end
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with runtime bounds, step, load/clear and wrap/saturate.
module updown_counter_n
  import updown_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      STEP_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_min,
  output logic              cfg_err
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic             w_count_en;
  dir_e             w_dir;
  mode_e            w_mode;

  assign w_dir      = up_down  ? DIR_UP   : DIR_DOWN;
  assign w_mode     = sat_mode ? MODE_SAT : MODE_WRAP;
  assign cfg_err    = (min_val > max_val);
  assign w_count_en = enable && !cfg_err && (step != '0);

  ud_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next_calc (
    .i_count   (r_count),
    .i_step    (step),
    .i_dir     (w_dir),
    .i_mode    (w_mode),
    .i_min     (min_val),
    .i_max     (max_val),
    .o_next    (w_next),
    .o_ovf_evt (w_ovf_evt),
    .o_unf_evt (w_unf_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RST_VAL;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clr) begin
      r_count <= min_val;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_count_en) begin
      r_count <= w_next;
      r_ovf   <= w_ovf_evt;
      r_unf   <= w_unf_evt;
    end else begin
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end
  end

  assign count  = r_count;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign at_max = (r_count == max_val);
  assign at_min = (r_count == min_val);

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed vector bench for updown_counter_n at WIDTH=4, STEP_W=4, RST_VAL=0.
module tb_updown_counter_n;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          up_down;
  logic [SW-1:0] step;
  logic          sat_mode;
  logic [W-1:0]  min_val;
  logic [W-1:0]  max_val;
  logic          clr;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic          ovf;
  logic          unf;
  logic          at_max;
  logic          at_min;
  logic          cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          clr;
    logic          load;
    logic [W-1:0]  lv;
    logic          en;
    logic          up;
    logic [SW-1:0] stp;
    logic          sat;
    logic [W-1:0]  mn;
    logic [W-1:0]  mx;
    logic [W-1:0]  e_cnt;
    logic          e_ovf;
    logic          e_unf;
    logic          e_amax;
    logic          e_amin;
    logic          e_cerr;
  } vec_t;

  vec_t vq[$];

  updown_counter_n #(
    .WIDTH   (W),
    .STEP_W  (SW),
    .RST_VAL (4'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .up_down  (up_down),
    .step     (step),
    .sat_mode (sat_mode),
    .min_val  (min_val),
    .max_val  (max_val),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .ovf      (ovf),
    .unf      (unf),
    .at_max   (at_max),
    .at_min   (at_min),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic av(input int c, input int l, input int lv, input int en, input int up,
                    input int stp, input int sat, input int mn, input int mx,
                    input int cnt, input int o, input int u, input int amax,
                    input int amin, input int cerr);
    vec_t v;
    v.clr    = (c != 0);
    v.load   = (l != 0);
    v.lv     = W'(lv);
    v.en     = (en != 0);
    v.up     = (up != 0);
    v.stp    = SW'(stp);
    v.sat    = (sat != 0);
    v.mn     = W'(mn);
    v.mx     = W'(mx);
    v.e_cnt  = W'(cnt);
    v.e_ovf  = (o != 0);
    v.e_unf  = (u != 0);
    v.e_amax = (amax != 0);
    v.e_amin = (amin != 0);
    v.e_cerr = (cerr != 0);
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    clr      = v.clr;
    load     = v.load;
    load_val = v.lv;
    enable   = v.en;
    up_down  = v.up;
    step     = v.stp;
    sat_mode = v.sat;
    min_val  = v.mn;
    max_val  = v.mx;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".count"},   32'(count),   32'(v.e_cnt));
    chk({tag, ".ovf"},     32'(ovf),     32'(v.e_ovf));
    chk({tag, ".unf"},     32'(unf),     32'(v.e_unf));
    chk({tag, ".at_max"},  32'(at_max),  32'(v.e_amax));
    chk({tag, ".at_min"},  32'(at_min),  32'(v.e_amin));
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(v.e_cerr));
  endtask

  initial begin
    vec_t h;
    rst = 1'b1;
    clr = 1'b0; load = 1'b0; load_val = '0; enable = 1'b0; up_down = 1'b0;
    step = '0; sat_mode = 1'b0; min_val = '0; max_val = 4'd15;
    #12;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.ovf",   32'(ovf),   32'd0);
    chk("reset.unf",   32'(unf),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    //  clr ld lv en up st sat mn mx | cnt ovf unf amax amin cerr
    av(0, 1, 15, 0, 0, 0, 0, 0, 15,   15, 0, 0, 1, 0, 0);
    av(0, 0,  0, 1, 1, 1, 0, 0, 15,    0, 1, 0, 0, 1, 0);
    av(0, 0,  0, 1, 1, 1, 0, 0, 15,    1, 0, 0, 0, 0, 0);
    av(0, 1,  5, 0, 0, 0, 0, 3, 12,    5, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 0, 4, 1, 3, 12,    3, 0, 1, 0, 1, 0);
    av(0, 0,  0, 1, 0, 4, 1, 3, 12,    3, 0, 1, 0, 1, 0);
    av(0, 0,  0, 1, 0, 4, 1, 3, 12,    3, 0, 1, 0, 1, 0);
    av(1, 1,  9, 1, 1, 2, 0, 2, 10,    2, 0, 0, 0, 1, 0);
    av(0, 1,  9, 0, 1, 2, 0, 2, 10,    9, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 1, 2, 0, 2, 10,    2, 1, 0, 0, 1, 0);
    av(0, 1, 12, 0, 0, 0, 0, 4,  8,   12, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 1, 1, 0, 4,  8,    4, 1, 0, 0, 1, 0);
    av(0, 1, 12, 0, 0, 0, 0, 4,  8,   12, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 0, 1, 0, 4,  8,   11, 0, 0, 0, 0, 0);
    av(0, 1,  1, 0, 0, 0, 0, 4,  8,    1, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 1, 1, 0, 4,  8,    2, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 0, 1, 0, 4,  8,    8, 0, 1, 1, 0, 0);
    av(0, 0,  0, 1, 1, 1, 0, 9,  3,    8, 0, 0, 0, 0, 1);
    av(1, 0,  0, 0, 1, 1, 0, 9,  3,    9, 0, 0, 0, 1, 1);
    av(0, 0,  0, 1, 1, 0, 0, 0, 15,    9, 0, 0, 0, 0, 0);
    av(0, 1, 10, 0, 0, 0, 0, 0, 15,   10, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 1, 8, 0, 0, 15,    0, 1, 0, 0, 1, 0);
    av(0, 1,  3, 0, 0, 0, 0, 0, 15,    3, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 0, 8, 1, 0, 15,    0, 0, 1, 0, 1, 0);
    av(0, 0,  0, 1, 0, 15, 0, 0, 15,  15, 0, 1, 1, 0, 0);
    av(0, 0,  0, 1, 1, 15, 1, 0, 15,  15, 1, 0, 1, 0, 0);
    av(0, 0,  0, 0, 1, 15, 1, 0, 15,  15, 0, 0, 1, 0, 0);
    av(0, 1, 13, 0, 0, 0, 0, 0, 15,   13, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 1, 2, 1, 0, 15,   15, 0, 0, 1, 0, 0);
    av(0, 1,  7, 0, 0, 0, 0, 3, 12,    7, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 0, 4, 0, 3, 12,    3, 0, 0, 0, 1, 0);
    av(0, 0,  0, 1, 0, 1, 0, 3, 12,   12, 0, 1, 1, 0, 0);
    av(0, 0,  0, 0, 1, 1, 1, 0, 10,   12, 0, 0, 0, 0, 0);
    av(0, 0,  0, 1, 1, 1, 1, 0, 10,   10, 1, 0, 1, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), vq[i]);
    end

    // Asynchronous reset between edges while an ovf pulse is showing.
    h = '{clr: 1'b0, load: 1'b1, lv: 4'd5, en: 1'b0, up: 1'b1, stp: 4'd1, sat: 1'b1,
          mn: 4'd0, mx: 4'd5, e_cnt: 4'd5, e_ovf: 1'b0, e_unf: 1'b0,
          e_amax: 1'b1, e_amin: 1'b0, e_cerr: 1'b0};
    drive(h);
    @(posedge clk); #1;
    check_outs("rst_pre_load", h);
    h.load = 1'b0; h.en = 1'b1; h.e_ovf = 1'b1;
    drive(h);
    @(posedge clk); #1;
    check_outs("rst_pre_ovf", h);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async.count", 32'(count), 32'd0);
    chk("rst_async.ovf",   32'(ovf),   32'd0);
    chk("rst_async.unf",   32'(unf),   32'd0);
    @(posedge clk); #1;
    chk("rst_held.count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release.count", 32'(count), 32'd1);
    chk("rst_release.ovf",   32'(ovf),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
Parametrised up/down counter. It is the next generation of the fixed 4-bit up/down counter.
- Adds configurable width, runtime min/max bounds, variable step, synchronous load and clear, and a wrap/saturate mode.
- Adds registered overflow and underflow event pulses.
- Used as a general event/position counter in datapath and timer logic.

Parameters:
WIDTH, 8, counter width in bits (2..32)
STEP_W, 4, width of step input (1..WIDTH)
RST_VAL, 0, value of count after reset (WIDTH bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
enable  input  1  count enable for this cycle
up_down  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement amount (unsigned)
sat_mode  input  1  1 = saturate at bound, 0 = wrap to opposite bound
min_val  input  WIDTH  lower bound (inclusive)
max_val  input  WIDTH  upper bound (inclusive)
clr  input  1  synchronous clear to min_val
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value for load
count  output  WIDTH  current count (registered)
ovf  output  1  one-cycle pulse: up step exceeded max_val (registered)
unf  output  1  one-cycle pulse: down step went below min_val (registered)
at_max  output  1  combinational: count == max_val
at_min  output  1  combinational: count == min_val
cfg_err  output  1  combinational: min_val > max_val

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- On rst: count = RST_VAL, ovf = 0, unf = 0, with no wait for clk.
- Per-edge priority: rst > clr > load > counting. The winning action takes effect on the same edge (1-cycle latency).
- clr: count <= min_val; ovf/unf <= 0.
- load: count <= load_val, taken verbatim with no clamping; ovf/unf <= 0.
- Counting occurs only when enable=1, cfg_err=0 and step!=0. Otherwise count holds and ovf/unf <= 0.
- Arithmetic is performed in WIDTH+1 bits, with step zero-extended. There is no silent modular wrap of the WIDTH-bit register.
- Up direction:
  - sum = count + step.
  - If sum <= max_val: count <= sum[WIDTH-1:0].
  - Otherwise this is an overflow event: ovf <= 1, and count <= min_val (wrap) or max_val (saturate).
- Down direction:
  - Underflow when count < min_val + step, compared in WIDTH+1 bits.
  - No underflow: count <= count - step.
  - Underflow: unf <= 1, and count <= max_val (wrap) or min_val (saturate).
- Saturate mode at a bound: holding at the bound while counting further still pulses ovf/unf every enabled cycle.
- Out-of-range count after load (count > max_val or count < min_val):
  - The next up step from above max_val is an overflow.
  - The next down step from below min_val is an underflow.
  - Steps toward the range proceed normally.
- Flags: ovf and unf are never both 1. Each is high for exactly one cycle per event.
- Bounds change mid-operation: new bounds apply from the next edge; count is not re-clamped.
- cfg_err=1 freezes counting only; clr and load still act.
- at_max/at_min follow count and the current bounds combinationally.

Decomposition:
- Package updown_counter_pkg:
  - dir_e {DIR_DOWN=0, DIR_UP=1}
  - mode_e {MODE_WRAP=0, MODE_SAT=1}
  - localparam WIDTH_MAX=32
- Sub-module ud_next_calc (combinational).
  - Inputs: count, step, direction, mode, bounds.
  - Outputs: next_count, ovf_evt, unf_evt.
  - The top module holds the registers, priority mux and flag registers.

Test Plan:
1. Reset mid-count: count=5, assert rst asynchronously between edges -> count=RST_VAL(0) immediately; ovf=unf=0.
2. Wrap up, WIDTH=4, min=0, max=15, step=1, sat=0, count=15, enable up -> count=0, ovf=1 for one cycle; next edge count=1, ovf=0.
3. Saturate down, min=3, max=12, step=4, sat=1, count=5 -> count=3, unf=1; enable held -> count stays 3, unf=1 each cycle.
4. Priority: clr=1, load=1, load_val=9, enable=1, min=2 -> count=2; then clr=0, load=1 -> count=9; then load=0, up step 2, max=10 -> overflow, wrap -> count=2, ovf=1.
5. Out-of-range load: min=4, max=8, load 12, then up step 1 -> ovf=1, count=4 (wrap); reload 12, down step 1 -> count=11, no flag.
6. Config error and step 0: min=9, max=3 -> cfg_err=1, enable up held, count unchanged; clr -> count=9. With valid bounds and step=0 -> count holds, no flags.
